la_footer_ctrl: RTL and testbench

Power-gating sequencer for one switchable domain. It drives the `nsleep` enables of an array of N `la_footer` switch segments, and coordinates isolation and retention around every power-down and power-up. It sits directly upstream of the footer array and is commanded by the system power manager through a 4-phase request/acknowledge handshake. Wake-up enables segments one at a time to limit rush current.

---
 rtl/la_footer_ctrl.sv | 161 ++++++++++++++++
 tb/tb_la_footer_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/la_footer_ctrl.sv
// Power-gating sequencer: ON -> ISO -> SAVE -> OFF -> WAKE (staggered) -> RESTORE -> ON.
// Latency: sleep request to ack is 3 cycles; wake takes N*STAGEDLY+1 cycles from OFF to ON.
// Backpressure: 4-phase level handshake; request changes mid-sequence are held off until ON/OFF.
//
// Ports:
//   clk        rising-edge clock
//   nreset     synchronous active-low reset (forces OFF values, marks next wake as cold)
//   sleep_req  1 = request domain off, 0 = request domain on
//   sleep_ack  1 = domain fully off, 0 = domain fully on
//   nsleep     per-segment footer enables (1 = conducting)
//   iso        output isolation clamp
//   save       one-cycle retention save strobe
//   restore    one-cycle retention restore strobe (suppressed on the first wake after reset)
module la_footer_ctrl #(
   parameter int N        = 4,
   parameter int STAGEDLY = 8,
   parameter     PROP     = "DEFAULT"
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic         sleep_req,
   output logic         sleep_ack,
   output logic [N-1:0] nsleep,
   output logic         iso,
   output logic         save,
   output logic         restore
);

   localparam int CNTW = (STAGEDLY > 1) ? $clog2(STAGEDLY) : 1;
   localparam int SEGW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(STAGEDLY - 1);
   localparam logic [SEGW-1:0] SEG_LAST = SEGW'(N - 1);

   typedef enum logic [2:0] {
      ST_ON      = 3'd0,
      ST_ISO     = 3'd1,
      ST_SAVE    = 3'd2,
      ST_OFF     = 3'd3,
      ST_WAKE    = 3'd4,
      ST_RESTORE = 3'd5
   } state_t;

   state_t          state, state_nxt;
   logic [CNTW-1:0] cnt, cnt_nxt;
   logic [SEGW-1:0] seg, seg_nxt;
   logic            cold, cold_nxt;

   logic [N-1:0]    nsleep_nxt;
   logic [N-1:0]    seg_onehot;
   logic            iso_nxt;
   logic            save_nxt;
   logic            restore_nxt;
   logic            sleep_ack_nxt;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state     <= ST_OFF;
         cnt       <= '0;
         seg       <= '0;
         cold      <= 1'b1;
         nsleep    <= '0;
         iso       <= 1'b1;
         save      <= 1'b0;
         restore   <= 1'b0;
         sleep_ack <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         seg       <= seg_nxt;
         cold      <= cold_nxt;
         nsleep    <= nsleep_nxt;
         iso       <= iso_nxt;
         save      <= save_nxt;
         restore   <= restore_nxt;
         sleep_ack <= sleep_ack_nxt;
      end
   end

   // Next state and counters.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      seg_nxt   = seg;
      cold_nxt  = cold;
      case (state)
         ST_ON: begin
            if (sleep_req) state_nxt = ST_ISO;
         end
         ST_ISO:  state_nxt = ST_SAVE;
         ST_SAVE: state_nxt = ST_OFF;
         ST_OFF: begin
            if (!sleep_req) begin
               state_nxt = ST_WAKE;
               cnt_nxt   = '0;
               seg_nxt   = '0;
            end
         end
         ST_WAKE: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               // After the last segment, the final interval serves as settle time.
               if (seg < SEG_LAST) seg_nxt = seg + SEGW'(1);
               else                state_nxt = ST_RESTORE;
            end else begin
               cnt_nxt = cnt + CNTW'(1);
            end
         end
         ST_RESTORE: begin
            state_nxt = ST_ON;
            cold_nxt  = 1'b0;
         end
         default: state_nxt = ST_OFF;
      endcase
   end

   // Registered outputs are decoded from the next state so they line up with it.
   always_comb begin
      seg_onehot = '0;
      for (int i = 0; i < N; i++) begin
         if (seg_nxt == SEGW'(i)) seg_onehot[i] = 1'b1;
      end

      nsleep_nxt    = '0;
      iso_nxt       = 1'b1;
      save_nxt      = 1'b0;
      restore_nxt   = 1'b0;
      sleep_ack_nxt = 1'b1;
      case (state_nxt)
         ST_ON: begin
            nsleep_nxt    = '1;
            iso_nxt       = 1'b0;
            sleep_ack_nxt = 1'b0;
         end
         ST_ISO: begin
            nsleep_nxt    = '1;
            sleep_ack_nxt = 1'b0;
         end
         ST_SAVE: begin
            nsleep_nxt    = '1;
            save_nxt      = 1'b1;
            sleep_ack_nxt = 1'b0;
         end
         ST_OFF: begin
            nsleep_nxt = '0;
         end
         ST_WAKE: begin
            // Enables only accumulate; nsleep is all-zero when arriving from OFF.
            nsleep_nxt = nsleep | seg_onehot;
         end
         ST_RESTORE: begin
            nsleep_nxt  = '1;
            // cold still holds its pre-exit value while in RESTORE.
            restore_nxt = !cold;
         end
         default: begin
            nsleep_nxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_la_footer_ctrl.sv
module tb_la_footer_ctrl;

   localparam int N  = 4;
   localparam int SD = 3;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         nreset, sleep_req;
   logic         sleep_ack, iso, save, restore;
   logic [N-1:0] nsleep;

   logic         nreset1, req1;
   logic         ack1, iso1, save1, rest1;
   logic [0:0]   ns1;

   int checks   = 0;
   int failures = 0;

   la_footer_ctrl #(.N(N), .STAGEDLY(SD), .PROP("DEFAULT")) dut (
      .clk(clk), .nreset(nreset), .sleep_req(sleep_req), .sleep_ack(sleep_ack),
      .nsleep(nsleep), .iso(iso), .save(save), .restore(restore)
   );

   la_footer_ctrl #(.N(1), .STAGEDLY(1), .PROP("DEFAULT")) dut1 (
      .clk(clk), .nreset(nreset1), .sleep_req(req1), .sleep_ack(ack1),
      .nsleep(ns1), .iso(iso1), .save(save1), .restore(rest1)
   );

   typedef struct {
      logic         rst_n;
      logic         req;
      logic [N-1:0] ns;
      logic         iso;
      logic         save;
      logic         rest;
      logic         ack;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic q, input logic [N-1:0] e_ns,
                      input logic e_iso, input logic e_save, input logic e_rest, input logic e_ack);
      vec_t v;
      v.rst_n = r; v.req = q; v.ns = e_ns; v.iso = e_iso;
      v.save = e_save; v.rest = e_rest; v.ack = e_ack;
      tbl.push_back(v);
   endtask

   // Expected wake waveform, c = cycles after the edge that leaves OFF (1-based).
   function automatic logic [N-1:0] wake_ns(input int c);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) if (c >= SD * i + 1) r[i] = 1'b1;
      return r;
   endfunction

   task automatic add_wake(input logic warm);
      for (int c = 1; c <= N * SD + 2; c++) begin
         add(1'b1, 1'b0, wake_ns(c), (c < N * SD + 2), 1'b0,
             warm && (c == N * SD + 1), (c < N * SD + 2));
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic inv(input string nm);
      chk({nm, "_iso_inv"}, {31'd0, (nsleep != '1) && !iso}, 32'd0);
      chk({nm, "_strobe_inv"}, {31'd0, save && restore}, 32'd0);
   endtask

   task automatic chk_out(input string nm, input logic [N-1:0] e_ns, input logic e_iso,
                          input logic e_save, input logic e_rest, input logic e_ack);
      chk(nm, {24'd0, nsleep, iso, save, restore, sleep_ack},
              {24'd0, e_ns, e_iso, e_save, e_rest, e_ack});
      inv(nm);
   endtask

   task automatic chk1(input string nm, input logic e_ns, input logic e_iso,
                       input logic e_save, input logic e_rest, input logic e_ack);
      chk(nm, {27'd0, ns1, iso1, save1, rest1, ack1}, {27'd0, e_ns, e_iso, e_save, e_rest, e_ack});
      chk({nm, "_iso_inv"}, {31'd0, (ns1 != 1'b1) && !iso1}, 32'd0);
   endtask

   initial begin
      nreset    = 1'b0;
      sleep_req = 1'b0;
      nreset1   = 1'b0;
      req1      = 1'b0;

      // Reset, cold wake, sleep, warm wake.
      add(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
      add_wake(1'b0);
      add(1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
      add(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
      add_wake(1'b1);

      for (int i = 0; i < tbl.size(); i++) begin
         nreset    = tbl[i].rst_n;
         sleep_req = tbl[i].req;
         step();
         chk_out($sformatf("row%0d", i), tbl[i].ns, tbl[i].iso, tbl[i].save,
                 tbl[i].rest, tbl[i].ack);
      end

      // Request dropped during SAVE: sleep still completes, wake starts one edge after OFF.
      sleep_req = 1'b1;
      step(); chk_out("tog_iso", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
      step(); chk_out("tog_save", 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
      sleep_req = 1'b0;
      step(); chk_out("tog_off", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
      step(); chk_out("tog_wake1", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
      // Request raised during WAKE: wake completes, sleep starts one edge after ON.
      sleep_req = 1'b1;
      for (int c = 2; c <= N * SD + 2; c++) begin
         step();
         chk_out($sformatf("tog_wake%0d", c), wake_ns(c), (c < N * SD + 2), 1'b0,
                 (c == N * SD + 1), (c < N * SD + 2));
      end
      step(); chk_out("tog_iso2", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
      step(); chk_out("tog_save2", 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
      step(); chk_out("tog_off2", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of WAKE with two segments enabled.
      sleep_req = 1'b0;
      for (int c = 1; c <= SD + 1; c++) step();
      chk_out("mid_wake", 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1);
      nreset = 1'b0;
      step(); chk_out("mid_reset", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
      nreset = 1'b1;

      // N=1, STAGEDLY=1: OFF exit to ON in 2 cycles.
      nreset1 = 1'b1;
      req1    = 1'b0;
      step(); chk1("b_wake", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(); chk1("b_restore_cold", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(); chk1("b_on", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      req1 = 1'b1;
      step(); chk1("b_iso", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(); chk1("b_save", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step(); chk1("b_off", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      req1 = 1'b0;
      step(); chk1("b_wake2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(); chk1("b_restore_warm", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step(); chk1("b_on2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
